// File: rtl/gray_binarize_packer.sv
// Binarizes each pixel against its local average plus an offset and packs the
// bits LSB-first into per-line words behind a 2-entry valid/ready output queue.
// Optional: define GRAY_BIN_VALID_CHECK_EN to require both valids and flag any disagreement.
module gray_binarize_packer #(
  parameter int         WORD_BITS     = 16,
  parameter int         LINE_WIDTH    = 640,
  parameter logic [7:0] THRESH_OFFSET = 8'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8:0]           in_pixel,
  input  logic                 in_pixel_valid,
  input  logic [7:0]           local_average,
  input  logic                 local_average_valid,
  output logic [WORD_BITS-1:0] out_word,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef GRAY_BIN_VALID_CHECK_EN
  output logic                 valid_mismatch,
`endif
  output logic                 overflow
);

  localparam int BW = $clog2(WORD_BITS);
  localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_BITS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(LINE_WIDTH - 1);

  function automatic logic [7:0] sat_thresh(input logic [7:0] avg);
    logic [8:0] sum;
    sum = {1'b0, avg} + {1'b0, THRESH_OFFSET};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  logic accept;
`ifdef GRAY_BIN_VALID_CHECK_EN
  assign accept = in_pixel_valid && local_average_valid;
  always_ff @(posedge clk) begin
    if (reset)                                     valid_mismatch <= 1'b0;
    else if (in_pixel_valid != local_average_valid) valid_mismatch <= 1'b1;
  end
`else
  logic unused_avg_valid;
  assign accept           = in_pixel_valid;
  assign unused_avg_valid = local_average_valid;
`endif

  logic [CW-1:0]        col;
  logic [BW-1:0]        bitpos;
  logic                 sof_pend;
  logic [WORD_BITS-1:0] shift_word_p1;

  // p0: threshold compare and placement of the bit in the current word
  logic [7:0]           thr_p0;
  logic                 bit_p0, sof_p0, done_p0, eol_p0, word_sof_p0;
  logic [BW-1:0]        pos_p0;
  logic [CW-1:0]        col_p0;
  logic [WORD_BITS-1:0] word_p0;

  always_comb begin
    thr_p0      = sat_thresh(local_average);
    bit_p0      = in_pixel[7:0] > thr_p0;
    sof_p0      = in_pixel[8];
    pos_p0      = sof_p0 ? '0 : bitpos;
    col_p0      = sof_p0 ? '0 : col;
    word_p0     = (pos_p0 == '0) ? '0 : shift_word_p1;
    word_p0[pos_p0] = bit_p0;
    eol_p0      = col_p0 == LAST_COL;
    done_p0     = (pos_p0 == LAST_BIT) || eol_p0;
    word_sof_p0 = sof_p0 || sof_pend;
  end

  // p1: packing state; the partial word needs no reset since bit 0 overwrites it
  always_ff @(posedge clk) begin
    if (accept) shift_word_p1 <= word_p0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col      <= '0;
      bitpos   <= '0;
      sof_pend <= 1'b0;
    end else if (accept) begin
      col      <= eol_p0 ? '0 : col_p0 + 1'b1;
      bitpos   <= done_p0 ? '0 : pos_p0 + 1'b1;
      sof_pend <= done_p0 ? 1'b0 : word_sof_p0;
    end
  end

  // output queue: 2-entry first-word-fall-through
  logic [WORD_BITS+1:0] fifo_mem [2];
  logic                 wr_ptr, rd_ptr;
  logic [1:0]           count;
  logic                 push, pop, full, do_write;
  logic [WORD_BITS+1:0] head;

  assign push     = accept && done_p0;
  assign full     = count == 2'd2;
  assign pop      = out_valid && out_ready;
  assign do_write = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_write) fifo_mem[wr_ptr] <= {word_sof_p0, eol_p0, word_p0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      case ({do_write, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign out_valid = count != 2'd0;
  assign out_word  = out_valid ? head[WORD_BITS-1:0] : '0;
  assign out_eol   = out_valid && head[WORD_BITS];
  assign out_sof   = out_valid && head[WORD_BITS+1];

endmodule

// File: tb/tb_gray_binarize_packer.sv
// Directed bench for gray_binarize_packer: two instances (8x8 line, offset 0;
// 8-bit words on a 20-pixel line, offset 200) with hand-computed expectations.
module tb_gray_binarize_packer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [8:0] pix_a, pix_b;
  logic       pv_a, pv_b, rdy_a, rdy_b;
  logic [7:0] avg_a, avg_b, word_a, word_b;
  logic       sof_a, eol_a, vld_a, ov_a;
  logic       sof_b, eol_b, vld_b, ov_b;
`ifdef GRAY_BIN_VALID_CHECK_EN
  logic       vm_a, vm_b;
`endif

  gray_binarize_packer #(.WORD_BITS(8), .LINE_WIDTH(8), .THRESH_OFFSET(8'd0)) dut_a (
    .clk(clk), .reset(reset), .in_pixel(pix_a), .in_pixel_valid(pv_a),
    .local_average(avg_a), .local_average_valid(pv_a),
    .out_word(word_a), .out_sof(sof_a), .out_eol(eol_a), .out_valid(vld_a),
    .out_ready(rdy_a),
`ifdef GRAY_BIN_VALID_CHECK_EN
    .valid_mismatch(vm_a),
`endif
    .overflow(ov_a));

  gray_binarize_packer #(.WORD_BITS(8), .LINE_WIDTH(20), .THRESH_OFFSET(8'd200)) dut_b (
    .clk(clk), .reset(reset), .in_pixel(pix_b), .in_pixel_valid(pv_b),
    .local_average(avg_b), .local_average_valid(pv_b),
    .out_word(word_b), .out_sof(sof_b), .out_eol(eol_b), .out_valid(vld_b),
    .out_ready(rdy_b),
`ifdef GRAY_BIN_VALID_CHECK_EN
    .valid_mismatch(vm_b),
`endif
    .overflow(ov_b));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic px_a(input logic sof, input logic [7:0] v, input logic [7:0] av);
    @(negedge clk);
    pix_a = {sof, v};
    avg_a = av;
    pv_a  = 1'b1;
  endtask

  task automatic idle_a();
    @(negedge clk);
    pv_a = 1'b0;
  endtask

  task automatic px_b(input logic sof, input logic [7:0] v, input logic [7:0] av);
    @(negedge clk);
    pix_b = {sof, v};
    avg_b = av;
    pv_b  = 1'b1;
  endtask

  logic [9:0] capq [$];
  always @(negedge clk) begin
    if (vld_b && rdy_b) capq.push_back({sof_b, eol_b, word_b});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [9:0] exp_b [5];
  logic [7:0] t1_pix [8];

  initial begin
    reset = 1'b1;
    pix_a = '0; pv_a = 1'b0; avg_a = '0; rdy_a = 1'b0;
    pix_b = '0; pv_b = 1'b0; avg_b = '0; rdy_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid_a", 64'(vld_a), 64'd0);
    check("rst_word_a",  64'(word_a), 64'd0);
    check("rst_sof_a",   64'(sof_a), 64'd0);
    check("rst_eol_a",   64'(eol_a), 64'd0);
    check("rst_ovf_a",   64'(ov_a), 64'd0);
    check("rst_valid_b", 64'(vld_b), 64'd0);
    reset = 1'b0;

    // basic 8-pixel line with SOF on the first pixel
    rdy_a = 1'b1;
    t1_pix = '{8'd99, 8'd100, 8'd101, 8'd200, 8'd0, 8'd255, 8'd100, 8'd150};
    for (int i = 0; i < 8; i++) px_a(i == 0, t1_pix[i], 8'd100);
    idle_a();
    check("t1_valid", 64'(vld_a), 64'd1);
    check("t1_word",  64'(word_a), 64'hAC);
    check("t1_sof",   64'(sof_a), 64'd1);
    check("t1_eol",   64'(eol_a), 64'd1);
    @(negedge clk);
    check("t1_drained", 64'(vld_a), 64'd0);

    // SOF mid-word discards the partial word
    for (int i = 0; i < 5; i++) px_a(1'b0, 8'd255, 8'd100);
    px_a(1'b1, 8'd255, 8'd100);
    for (int i = 0; i < 7; i++) px_a(1'b0, 8'd0, 8'd100);
    idle_a();
    check("sof_valid", 64'(vld_a), 64'd1);
    check("sof_word",  64'(word_a), 64'h01);
    check("sof_sof",   64'(sof_a), 64'd1);
    check("sof_eol",   64'(eol_a), 64'd1);
    @(negedge clk);
    check("sof_single", 64'(vld_a), 64'd0);

    // backpressure: two words held, third dropped
    rdy_a = 1'b0;
    for (int i = 0; i < 8; i++) px_a(1'b0, (i < 4) ? 8'd255 : 8'd0, 8'd100);
    for (int i = 0; i < 8; i++) px_a(1'b0, (i < 4) ? 8'd0 : 8'd255, 8'd100);
    idle_a();
    check("ovf_not_yet", 64'(ov_a), 64'd0);
    check("ovf_head0",   64'(word_a), 64'h0F);
    for (int i = 0; i < 8; i++) px_a(1'b0, 8'd255, 8'd100);
    idle_a();
    check("ovf_set",     64'(ov_a), 64'd1);
    check("ovf_valid",   64'(vld_a), 64'd1);
    check("ovf_head1",   64'(word_a), 64'h0F);
    @(negedge clk);
    check("ovf_stable",  64'(word_a), 64'h0F);
    rdy_a = 1'b1;
    @(negedge clk);
    check("drain_valid", 64'(vld_a), 64'd1);
    check("drain_word",  64'(word_a), 64'hF0);
    check("drain_sof",   64'(sof_a), 64'd0);
    check("drain_eol",   64'(eol_a), 64'd1);
    @(negedge clk);
    check("drain_empty", 64'(vld_a), 64'd0);
    check("ovf_sticky",  64'(ov_a), 64'd1);

    // reset with a queued word and a partial word pending
    rdy_a = 1'b0;
    for (int i = 0; i < 11; i++) px_a(1'b0, 8'd255, 8'd100);
    idle_a();
    check("prerst_valid", 64'(vld_a), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("postrst_valid", 64'(vld_a), 64'd0);
    check("postrst_ovf",   64'(ov_a), 64'd0);
    check("postrst_word",  64'(word_a), 64'd0);
    rdy_a = 1'b1;
    for (int i = 0; i < 8; i++) px_a(1'b0, (i == 0) ? 8'd255 : 8'd0, 8'd100);
    idle_a();
    check("fresh_valid", 64'(vld_a), 64'd1);
    check("fresh_word",  64'(word_a), 64'h01);
    check("fresh_sof",   64'(sof_a), 64'd0);
    check("fresh_eol",   64'(eol_a), 64'd1);

    // 20-pixel line of 8-bit words, then saturating threshold
    rdy_b = 1'b1;
    for (int i = 0; i < 20; i++) px_b(i == 0, 8'd255, 8'd10);
    for (int i = 0; i < 8; i++)  px_b(1'b0, (i == 0) ? 8'd255 : 8'd0, 8'd10);
    px_b(1'b0, 8'd255, 8'd100);
    px_b(1'b0, 8'd254, 8'd50);
    for (int i = 0; i < 6; i++)  px_b(1'b0, 8'd0, 8'd50);
    @(negedge clk);
    pv_b = 1'b0;
    repeat (2) @(negedge clk);
    exp_b = '{{1'b1, 1'b0, 8'hFF}, {1'b0, 1'b0, 8'hFF}, {1'b0, 1'b1, 8'h0F},
              {1'b0, 1'b0, 8'h01}, {1'b0, 1'b0, 8'h02}};
    check("b_count", 64'(capq.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("b_word%0d", i), 64'((i < capq.size()) ? capq[i] : 10'h3FF), 64'(exp_b[i]));
    check("b_ovf", 64'(ov_b), 64'd0);
`ifdef GRAY_BIN_VALID_CHECK_EN
    check("vm_a", 64'(vm_a), 64'd0);
    check("vm_b", 64'(vm_b), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
